cpld_ram_bank_seq: RTL and testbench

Bank-configuration controller for the 512K CPC RAM expansion. It decodes Z80 I/O writes to the 0x7FXX config port (data 0b11cccbbb) and holds the write as a pending configuration. It applies the configuration to the ramblock register only at a safe point, when no memory cycle is in flight, so the mapping logic never sees a bank change mid-cycle. It also rejects writes to uninstalled banks and counts applied switches for debug.

---
 rtl/cpld_ram_pkg.sv | 17 +
 rtl/cpld_io_wr_detect.sv | 32 +++
 rtl/cpld_ram_bank_seq.sv | 120 ++++++++++++
 tb/tb_cpld_ram_bank_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpld_ram_pkg.sv
// Shared encodings for the 512K CPC RAM expansion bank-configuration logic.
package cpld_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } cfg_state_e;

  localparam logic [1:0] CFG_SEL   = 2'b11;
  localparam int         BANK_MSB  = 5;
  localparam int         BANK_LSB  = 3;
  localparam int         MODE_MSB  = 2;
  localparam int         MODE_LSB  = 0;
  localparam int         MAX_BANKS = 8;

endpackage

// File: rtl/cpld_io_wr_detect.sv
// Decodes Z80 writes to the 0x7FXX config port and emits one strobe per I/O cycle.
module cpld_io_wr_detect
  import cpld_ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_b,
  input  logic       wr_b,
  input  logic       adr15,
  input  logic [7:0] data,
  output logic       cap_stb,
  output logic [5:0] cap_data
);

  logic hit;
  logic hit_q;

  assign hit = ~iorq_b & ~wr_b & ~adr15 & (data[7:6] == CFG_SEL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit;
    end
  end

  // Rising edge of hit only: a Z80 write spans several clocks.
  assign cap_stb  = hit & ~hit_q;
  assign cap_data = data[5:0];

endmodule

// File: rtl/cpld_ram_bank_seq.sv
// Holds a captured bank config and applies it to ramblock only after the bus has been
// quiet (mreq_b high) long enough that no memory cycle is in flight.
module cpld_ram_bank_seq
  import cpld_ram_pkg::*;
#(
  parameter int unsigned INSTALLED_BANKS = 8,
  parameter int unsigned SAFE_CYCLES     = 2,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iorq_b,
  input  logic             wr_b,
  input  logic             adr15,
  input  logic             mreq_b,
  input  logic [7:0]       data,
  output logic [5:0]       ramblock,
  output logic             cfg_pending,
  output logic             cfg_update,
  output logic             cfg_err,
  output logic [CNT_W-1:0] switch_count
);

  localparam logic [3:0] INST4 = 4'(INSTALLED_BANKS);
  localparam logic [3:0] SAFE4 = 4'(SAFE_CYCLES);

  logic       cap_stb;
  logic [5:0] cap_data;
  logic       bank_ok;

  cfg_state_e       state_q, state_d;
  logic [5:0]       pend_q, pend_d;
  logic [3:0]       idle_q, idle_d;
  logic [5:0]       ram_q, ram_d;
  logic             pending_q, pending_d;
  logic             upd_q, upd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cpld_io_wr_detect u_wr_detect (
    .clk      (clk),
    .reset    (reset),
    .iorq_b   (iorq_b),
    .wr_b     (wr_b),
    .adr15    (adr15),
    .data     (data),
    .cap_stb  (cap_stb),
    .cap_data (cap_data)
  );

  assign bank_ok = {1'b0, cap_data[BANK_MSB:BANK_LSB]} < INST4;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idle_d  = idle_q;
    ram_d   = ram_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: ;
      PEND: begin
        idle_d = mreq_b ? idle_q + 4'd1 : 4'd0;
        if (idle_d == SAFE4) state_d = APPLY;
      end
      APPLY: begin
        ram_d   = pend_q;
        upd_d   = 1'b1;
        cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        idle_d  = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A capture overrides the schedule; APPLY above still uses the old pend_q.
    if (cap_stb) begin
      if (bank_ok) begin
        pend_d  = cap_data;
        idle_d  = 4'd0;
        state_d = PEND;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign pending_d = (state_d == PEND) | (state_d == APPLY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      idle_q    <= '0;
      ram_q     <= '0;
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      idle_q    <= idle_d;
      ram_q     <= ram_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ramblock     = ram_q;
  assign cfg_pending  = pending_q;
  assign cfg_update   = upd_q;
  assign cfg_err      = err_q;
  assign switch_count = cnt_q;

endmodule

// File: tb/tb_cpld_ram_bank_seq.sv
// Directed plus random stimulus against a behavioural model of the bank-switch rules.
module tb_cpld_ram_bank_seq;

  localparam int unsigned IB = 5;
  localparam int unsigned SC = 2;
  localparam int unsigned CW = 3;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          iorq_b = 1'b1;
  logic          wr_b = 1'b1;
  logic          adr15 = 1'b1;
  logic          mreq_b = 1'b1;
  logic [7:0]    data = 8'h00;
  logic [5:0]    ramblock;
  logic          cfg_pending;
  logic          cfg_update;
  logic          cfg_err;
  logic [CW-1:0] switch_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a pending config waits for SC quiet clocks, then applies on the following edge.
  logic       m_prev_hit;
  logic [5:0] m_ram, m_pend;
  bit         m_wait, m_apply, m_upd, m_err;
  int         m_quiet, m_cnt;

  cpld_ram_bank_seq #(
    .INSTALLED_BANKS (IB),
    .SAFE_CYCLES     (SC),
    .CNT_W           (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .iorq_b       (iorq_b),
    .wr_b         (wr_b),
    .adr15        (adr15),
    .mreq_b       (mreq_b),
    .data         (data),
    .ramblock     (ramblock),
    .cfg_pending  (cfg_pending),
    .cfg_update   (cfg_update),
    .cfg_err      (cfg_err),
    .switch_count (switch_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_prev_hit = 1'b0;
    m_ram      = '0;
    m_pend     = '0;
    m_wait     = 0;
    m_apply    = 0;
    m_upd      = 0;
    m_err      = 0;
    m_quiet    = 0;
    m_cnt      = 0;
  endtask

  task automatic model_step();
    bit hit, cap;
    hit = !iorq_b && !wr_b && !adr15 && data[7] && data[6];
    cap = hit && !m_prev_hit;
    m_prev_hit = hit;
    m_upd = 0;
    m_err = 0;
    if (m_apply) begin
      m_ram = m_pend;
      m_upd = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
      m_apply = 0;
    end else if (m_wait) begin
      m_quiet = mreq_b ? m_quiet + 1 : 0;
      if (m_quiet == SC) begin
        m_wait  = 0;
        m_apply = 1;
      end
    end
    if (cap) begin
      if (int'(data[5:3]) < IB) begin
        m_pend  = data[5:0];
        m_wait  = 1;
        m_apply = 0;
        m_quiet = 0;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("ramblock", 32'(ramblock), 32'(m_ram));
    check("cfg_pending", 32'(cfg_pending), 32'(m_wait || m_apply));
    check("cfg_update", 32'(cfg_update), 32'(m_upd));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    check("switch_count", 32'(switch_count), 32'(m_cnt));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic io_write(input logic [7:0] d, input int hold);
    iorq_b = 1'b0;
    wr_b   = 1'b0;
    adr15  = 1'b0;
    data   = d;
    repeat (hold) tick();
    iorq_b = 1'b1;
    wr_b   = 1'b1;
    adr15  = 1'b1;
    tick();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    reset = 1'b0;
    tick();

    // Held hit captures once; apply SC+1 clocks after the capture edge.
    io_write(8'hC2, 3);
    repeat (3) tick();
    check("first_apply_ram", 32'(ramblock), 32'h02);
    check("first_apply_cnt", 32'(switch_count), 32'd1);

    // Busy memory bus holds off the apply.
    mreq_b = 1'b0;
    io_write(8'hC9, 1);
    repeat (10) tick();
    check("held_off_ram", 32'(ramblock), 32'h02);
    mreq_b = 1'b1;
    repeat (4) tick();
    check("late_apply_ram", 32'(ramblock), 32'h09);

    // Uninstalled bank (ccc = IB) is rejected.
    io_write(8'hC0 | 8'(IB << 3), 1);
    repeat (4) tick();

    // Last write wins; single apply.
    io_write(8'hC4, 1);
    io_write(8'hC7, 1);
    repeat (5) tick();
    check("last_wins_ram", 32'(ramblock), 32'h07);

    // Async reset in PEND discards the pending config.
    io_write(8'hC1, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    repeat (6) tick();

    // Drive switch_count into saturation, including repeats of the same value.
    for (int i = 0; i < 10; i++) begin
      io_write(8'hC3, 1 + (i % 2));
      repeat (4) tick();
    end
    check("saturated_cnt", 32'(switch_count), 32'(CNT_MAX));

    // Random bus traffic.
    for (int i = 0; i < 600; i++) begin
      iorq_b = ($urandom_range(0, 5) != 0);
      wr_b   = ($urandom_range(0, 3) == 0);
      adr15  = ($urandom_range(0, 7) == 0);
      mreq_b = ($urandom_range(0, 3) != 0);
      data   = 8'($urandom);
      if ($urandom_range(0, 1) == 1) data[7:6] = 2'b11;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
